// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: PC / IF/ID / ID/EX enables and flushes for
// load-use, taken-branch, imem wait-state and mul/div occupancy, plus a stall counter.
module hazard_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        ID_use_rs,
  input  logic        ID_use_rt,
  input  logic        ID_md,
  input  logic        ID_md_div,
  input  logic        EX_memread,
  input  logic [4:0]  EX_rd,
  input  logic        EX_br_taken,
  input  logic        imem_ready,
  output logic        pc_en,
  output logic        IFID_en,
  output logic        IFID_flush,
  output logic        IDEX_flush,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  typedef enum logic {RUN, MD_WAIT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      stall_cnt_q, stall_cnt_d;
  logic             load_use;

  always_comb begin
    load_use = EX_memread && (EX_rd != 5'd0) &&
               ((ID_use_rs && (ID_rs == EX_rd)) || (ID_use_rt && (ID_rt == EX_rd)));

    pc_en       = 1'b1;
    IFID_en     = 1'b1;
    IFID_flush  = 1'b0;
    IDEX_flush  = 1'b0;
    md_busy     = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_cnt_d = stall_cnt_q;

    if (rst) begin
      pc_en       = 1'b0;
      IFID_en     = 1'b0;
      IFID_flush  = 1'b1;
      IDEX_flush  = 1'b1;
      state_d     = RUN;
      cnt_d       = '0;
      stall_cnt_d = '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (EX_br_taken) begin
            IFID_flush = 1'b1;
            IDEX_flush = 1'b1;
          end else if (load_use) begin
            pc_en      = 1'b0;
            IFID_en    = 1'b0;
            IDEX_flush = 1'b1;
          end else begin
            // an imem miss only starves IF; a mul/div in ID may still issue
            if (!imem_ready) begin
              pc_en      = 1'b0;
              IFID_flush = 1'b1;
            end
            if (ID_md) begin
              state_d = MD_WAIT;
              cnt_d   = ID_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
            end
          end
        end
        MD_WAIT: begin
          md_busy    = 1'b1;
          pc_en      = 1'b0;
          IFID_en    = 1'b0;
          IDEX_flush = 1'b1;
          if (cnt_q <= CNT_W'(1)) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase

      if (!pc_en) stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    cnt_q       <= cnt_d;
    stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule
